// File: rtl/riscv_definitions.sv
// Shared RV32I definitions for the execute stage.
//   alu_ops_t    : operation select for the alu module
//   OPC_*        : 7-bit major opcodes decoded by execute_stage
//   F3_*         : funct3 encodings for the ALU and branch groups
package riscv_definitions;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_ops_t;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU.
//   a_i, b_i  : operands
//   op_i      : operation select (alu_ops_t)
//   result_o  : result; add/sub wrap modulo 2^32, shifts use b_i[4:0]
//   zero_o    : result_o == 0 (used for branch resolution)
module alu
  import riscv_definitions::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ops_t    op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SLT: result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SRL: result_o = a_i >> b_i[4:0];
      ALU_SRA: result_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:  result_o = a_i | b_i;
      ALU_AND: result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: decodes an instruction, runs it through the ALU,
// resolves branches and holds the result in a one-entry output register.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : decode-to-execute handshake
//   in_opcode/funct3/funct7b5, in_rs1_val/rs2_val/imm/pc, in_rd : instruction
//   flush                 : drop held and incoming instruction
//   out_valid/out_ready   : execute-to-memory handshake
//   out_result/rd/we/branch_taken/branch_target/illegal : registered results
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid and its payload stable until the transfer;
// ready may depend combinationally on the consumer side (in_ready follows
// out_ready and flush), never on in_valid.
module execute_stage
  import riscv_definitions::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_branch_taken,
  output logic [31:0] out_branch_target,
  output logic        out_illegal
);

  logic        valid_q;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q;
  logic        we_q, we_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;
  logic        illegal_q, illegal_d;

  alu_ops_t    alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        is_branch, writes_rd;
  logic        accept;

  // Decode and operand selection.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_a     = in_rs1_val;
    alu_b     = in_rs2_val;
    illegal_d = 1'b0;
    is_branch = 1'b0;
    writes_rd = 1'b0;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        writes_rd = 1'b1;
        alu_b     = (in_opcode == OPC_OP) ? in_rs2_val : in_imm;
        case (in_funct3)
          // funct7b5 selects SUB only for register-register ops; ADDI has
          // immediate bits in that position.
          F3_ADD_SUB: alu_op = (in_opcode == OPC_OP && in_funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SRL_SRA: alu_op = in_funct7b5 ? ALU_SRA : ALU_SRL;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    illegal_d = 1'b1;  // SLTU not supported
        endcase
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (in_funct3)
          F3_BEQ, F3_BNE: alu_op = ALU_SUB;
          F3_BLT, F3_BGE: alu_op = ALU_SLT;
          default:        illegal_d = 1'b1;
        endcase
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        alu_a     = '0;
        alu_b     = in_imm;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        alu_a     = in_pc;
        alu_b     = in_imm;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Branch resolution from the ALU zero flag: SUB==0 means equal,
  // SLT!=0 means less-than.
  always_comb begin
    taken_d = 1'b0;
    if (is_branch && !illegal_d) begin
      case (in_funct3)
        F3_BEQ:  taken_d = alu_zero;
        F3_BNE:  taken_d = !alu_zero;
        F3_BLT:  taken_d = !alu_zero;
        F3_BGE:  taken_d = alu_zero;
        default: taken_d = 1'b0;
      endcase
    end
  end

  assign result_d = illegal_d ? 32'd0 : alu_result;
  assign we_d     = writes_rd && !illegal_d && (in_rd != 5'd0);
  assign target_d = in_pc + in_imm;  // separate adder, not shared with ALU

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Flush wins over accept and hold. Payload registers only load on accept,
  // so they stay stable while the result is waiting for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      result_q  <= result_d;
      rd_q      <= in_rd;
      we_q      <= we_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid         = valid_q;
  assign out_result        = result_q;
  assign out_rd            = rd_q;
  assign out_we            = we_q;
  assign out_branch_taken  = taken_q;
  assign out_branch_target = target_q;
  assign out_illegal       = illegal_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized
// traffic, checked by a queue-based scoreboard fed from a reference model.
module tb_execute_stage;

  localparam int W = 72;  // {result, rd, we, taken, target, illegal}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_branch_taken;
  logic [31:0] out_branch_target;
  logic        out_illegal;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_funct3         (in_funct3),
    .in_funct7b5       (in_funct7b5),
    .in_rs1_val        (in_rs1_val),
    .in_rs2_val        (in_rs2_val),
    .in_imm            (in_imm),
    .in_pc             (in_pc),
    .in_rd             (in_rd),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_rd            (out_rd),
    .out_we            (out_we),
    .out_branch_taken  (out_branch_taken),
    .out_branch_target (out_branch_target),
    .out_illegal       (out_illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic f7, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic [4:0] rd);
    logic [31:0] r, b;
    logic tk, ill, wr, lt, we;
    r = 32'd0; tk = 1'b0; ill = 1'b0; wr = 1'b0;
    case (opc)
      7'b0110011, 7'b0010011: begin
        wr = 1'b1;
        b  = (opc == 7'b0110011) ? rs2 : imm;
        case (f3)
          3'd0: r = (opc == 7'b0110011 && f7) ? rs1 - b : rs1 + b;
          3'd1: r = rs1 << b[4:0];
          3'd2: r = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: ill = 1'b1;
          3'd4: r = rs1 ^ b;
          3'd5: begin
            if (f7) r = $signed(rs1) >>> b[4:0];
            else    r = rs1 >> b[4:0];
          end
          3'd6: r = rs1 | b;
          default: r = rs1 & b;
        endcase
      end
      7'b1100011: begin
        lt = $signed(rs1) < $signed(rs2);
        case (f3)
          3'd0: begin r = rs1 - rs2; tk = (rs1 == rs2); end
          3'd1: begin r = rs1 - rs2; tk = (rs1 != rs2); end
          3'd4: begin r = lt ? 32'd1 : 32'd0; tk = lt; end
          3'd5: begin r = lt ? 32'd1 : 32'd0; tk = !lt; end
          default: ill = 1'b1;
        endcase
      end
      7'b0110111: begin wr = 1'b1; r = imm; end
      7'b0010111: begin wr = 1'b1; r = pc + imm; end
      default: ill = 1'b1;
    endcase
    if (ill) begin r = 32'd0; tk = 1'b0; end
    we = wr && !ill && (rd != 5'd0);
    return {r, rd, we, tk, pc + imm, ill};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of stimulus at the falling edge; predicts in_ready from
  // the scoreboard occupancy and pushes the expected result once the
  // transfer edge has passed.
  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       input logic ordy, input logic fl);
    logic exp_ready, acc;
    @(negedge clk);
    in_valid = v; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
    out_ready = ordy; flush = fl;
    #2;
    exp_ready = ((exp_q.size() == 0) || ordy) && !fl;
    chk("in_ready", W'(in_ready), W'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(model(opc, f3, f7, rs1, rs2, imm, pc, rd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // While an entry is outstanding the DUT must present it unchanged; it
  // leaves the queue when consumed (out_ready) or discarded (flush).
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          chk("out_bundle", {out_result, out_rd, out_we, out_branch_taken,
                             out_branch_target, out_illegal}, exp_q[0]);
          if (out_ready || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- random helpers ----------------
  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 40));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] rnd_opc();
    case ($urandom_range(0, 7))
      0, 1:    return 7'b0110011;
      2:       return 7'b0010011;
      3, 4:    return 7'b1100011;
      5:       return 7'b0110111;
      6:       return 7'b0010111;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"},   W'(out_valid), '0);
    chk({tag, "_result"},  W'(out_result), '0);
    chk({tag, "_rd"},      W'(out_rd), '0);
    chk({tag, "_we"},      W'(out_we), '0);
    chk({tag, "_taken"},   W'(out_branch_taken), '0);
    chk({tag, "_target"},  W'(out_branch_target), '0);
    chk({tag, "_illegal"}, W'(out_illegal), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_pc = '0; in_rd = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 5+7 -> rd3
    drive(1, 7'b0110011, 3'd0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1, 0);
    chk("add_valid", W'(out_valid), W'(1));
    chk("add_result", W'(out_result), W'(12));
    chk("add_we", W'(out_we), W'(1));
    chk("add_rd", W'(out_rd), W'(3));

    // SUB 0-1 and SRA 0x80000000 by 33 (shift of 1)
    drive(1, 7'b0110011, 3'd0, 1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd1, 1, 0);
    chk("sub_result", W'(out_result), W'(32'hFFFF_FFFF));
    drive(1, 7'b0110011, 3'd5, 1, 32'h8000_0000, 32'd33, 32'd0, 32'd0, 5'd1, 1, 0);
    chk("sra_result", W'(out_result), W'(32'hC000_0000));

    // BLT / BGE with -1 vs 1
    drive(1, 7'b1100011, 3'd4, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 5'd4, 1, 0);
    chk("blt_taken", W'(out_branch_taken), W'(1));
    chk("blt_target", W'(out_branch_target), W'(32'hF8));
    chk("blt_we", W'(out_we), W'(0));
    drive(1, 7'b1100011, 3'd5, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 5'd4, 1, 0);
    chk("bge_taken", W'(out_branch_taken), W'(0));

    // Illegal encodings and rd=0
    drive(1, 7'b0000011, 3'd0, 0, 32'd9, 32'd9, 32'd4, 32'd0, 5'd5, 1, 0);
    chk("load_illegal", W'(out_illegal), W'(1));
    chk("load_we", W'(out_we), W'(0));
    chk("load_result", W'(out_result), W'(0));
    drive(1, 7'b0110011, 3'd3, 0, 32'd9, 32'd9, 32'd0, 32'd0, 5'd5, 1, 0);
    chk("sltu_illegal", W'(out_illegal), W'(1));
    chk("sltu_result", W'(out_result), W'(0));
    drive(1, 7'b0110011, 3'd0, 0, 32'd2, 32'd3, 32'd0, 32'd0, 5'd0, 1, 0);
    chk("rd0_we", W'(out_we), W'(0));
    chk("rd0_result", W'(out_result), W'(5));

    // Backpressure: hold for 3 cycles, then accept the waiting instruction
    drive(1, 7'b0110011, 3'd0, 0, 32'd100, 32'd1, 32'd0, 32'd0, 5'd7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'b0110011, 3'd4, 0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd8, 0, 0);
      chk("hold_in_ready", W'(in_ready), W'(0));
      chk("hold_result", W'(out_result), W'(101));
    end
    drive(1, 7'b0110011, 3'd4, 0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd8, 1, 0);
    chk("release_result", W'(out_result), W'(32'hFF));
    chk("release_rd", W'(out_rd), W'(8));

    // Flush while holding with a new instruction offered
    drive(1, 7'b0110011, 3'd0, 0, 32'd100, 32'd1, 32'd0, 32'd0, 5'd7, 1, 0);
    drive(1, 7'b0110011, 3'd4, 0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd8, 0, 1);
    chk("flush_valid", W'(out_valid), W'(0));
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 3) != 0, rnd_opc(), 3'($urandom), 1'($urandom),
            rnd32(), rnd32(), rnd32(), rnd32(), rd,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(3);

    // Reset while holding an instruction
    drive(1, 7'b0110111, 3'd0, 0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd9, 1, 0);
    drive(0, 7'd0, 3'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post_reset_in_ready", W'(in_ready), W'(1));
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
